// File: rtl/slink_chn_sel_if.sv
// Channel health/busy inputs and selection outputs of slink_chn_sel.
// master: the selector itself; slave: the consumer of the selection.
interface slink_chn_sel_if;
  logic       chn_a_err;
  logic       chn_b_err;
  logic       chn_a_busy;
  logic       chn_b_busy;
  logic       sel_chn;
  logic       sel_valid;
  logic       sw_pulse;
  logic [7:0] sw_cnt;
  logic       drain_busy;

  modport master (
    input  chn_a_err, chn_b_err, chn_a_busy, chn_b_busy,
    output sel_chn, sel_valid, sw_pulse, sw_cnt, drain_busy
  );

  modport slave (
    output chn_a_err, chn_b_err, chn_a_busy, chn_b_busy,
    input  sel_chn, sel_valid, sw_pulse, sw_cnt, drain_busy
  );
endinterface

// File: rtl/slink_chn_sel.sv
// A/B channel selector with per-channel recovery hold-off and switchover counter.
// Define SLINK_REVERT_EN to revert to A at the next B packet boundary once A recovers.
module slink_chn_sel #(
  parameter logic [15:0] RECOV_CYCLES = 16'd1000
) (
  input logic             clk_125m,
  input logic             rst_125m,
  slink_chn_sel_if.master bus
);

`ifdef SLINK_REVERT_EN
  typedef enum logic [1:0] {NONE = 2'd0, ACT_A = 2'd1, ACT_B = 2'd2, DRAIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {NONE = 2'd0, ACT_A = 2'd1, ACT_B = 2'd2} state_t;
`endif

  state_t      state, next;
  logic [15:0] cnt_a, cnt_b;
  logic        a_ok, b_ok;
  logic        nxt_valid, nxt_chn, change;
  logic        sel_chn, sel_valid, sw_pulse, drain_busy;
  logic [7:0]  sw_cnt;
  logic        unused_busy;

  always_ff @(posedge clk_125m) begin
    if (rst_125m || bus.chn_a_err)  cnt_a <= '0;
    else if (cnt_a != RECOV_CYCLES) cnt_a <= cnt_a + 16'd1;
  end

  always_ff @(posedge clk_125m) begin
    if (rst_125m || bus.chn_b_err)  cnt_b <= '0;
    else if (cnt_b != RECOV_CYCLES) cnt_b <= cnt_b + 16'd1;
  end

  assign a_ok = !bus.chn_a_err && (cnt_a == RECOV_CYCLES);
  assign b_ok = !bus.chn_b_err && (cnt_b == RECOV_CYCLES);

  always_ff @(posedge clk_125m) begin
    if (rst_125m) state <= NONE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      NONE: begin
        if (a_ok)      next = ACT_A;
        else if (b_ok) next = ACT_B;
      end
      ACT_A: begin
        if (!a_ok) next = b_ok ? ACT_B : NONE;
      end
      ACT_B: begin
        if (!b_ok) next = a_ok ? ACT_A : NONE;
`ifdef SLINK_REVERT_EN
        else if (a_ok) next = DRAIN;
`endif
      end
`ifdef SLINK_REVERT_EN
      DRAIN: begin
        if (!b_ok && a_ok)       next = ACT_A;
        else if (!a_ok && b_ok)  next = ACT_B;
        else if (!a_ok && !b_ok) next = NONE;
        else if (!bus.chn_b_busy) next = ACT_A;
      end
`endif
      default: next = NONE;
    endcase
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state register.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_chn   = sel_chn;
    case (next)
      ACT_A: begin nxt_valid = 1'b1; nxt_chn = 1'b0; end
      ACT_B: begin nxt_valid = 1'b1; nxt_chn = 1'b1; end
`ifdef SLINK_REVERT_EN
      DRAIN: begin nxt_valid = 1'b1; nxt_chn = 1'b1; end
`endif
      default: ;
    endcase
    change = (nxt_valid && !sel_valid) || (nxt_chn != sel_chn);
  end

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      sel_chn   <= 1'b0;
      sel_valid <= 1'b0;
      sw_pulse  <= 1'b0;
      sw_cnt    <= '0;
    end else begin
      sel_chn   <= nxt_chn;
      sel_valid <= nxt_valid;
      sw_pulse  <= change;
      if (change && (sw_cnt != 8'hFF)) sw_cnt <= sw_cnt + 8'd1;
    end
  end

`ifdef SLINK_REVERT_EN
  always_ff @(posedge clk_125m) begin
    if (rst_125m) drain_busy <= 1'b0;
    else          drain_busy <= (next == DRAIN);
  end
`else
  assign drain_busy = 1'b0;
`endif

  // Channel A busy never gates a decision; B busy only matters for revert.
  assign unused_busy = bus.chn_a_busy ^ bus.chn_b_busy;

  assign bus.sel_chn    = sel_chn;
  assign bus.sel_valid  = sel_valid;
  assign bus.sw_pulse   = sw_pulse;
  assign bus.sw_cnt     = sw_cnt;
  assign bus.drain_busy = drain_busy;

endmodule

// File: tb/tb_slink_chn_sel.sv
// Directed test of slink_chn_sel with RECOV_CYCLES=16; revert steps are
// exercised only when SLINK_REVERT_EN is defined.
module tb_slink_chn_sel;
  logic clk_125m = 1'b0;
  logic rst_125m;
  int   total = 0;
  int   bad   = 0;

  slink_chn_sel_if bus ();

  slink_chn_sel #(.RECOV_CYCLES(16'd16)) dut (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .bus      (bus.master)
  );

  always #5 clk_125m = ~clk_125m;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_125m);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic chn,
                           input logic pulse, input logic [7:0] cnt, input logic drain);
    check({tag, ".sel_valid"},  {15'd0, bus.sel_valid},  {15'd0, valid});
    check({tag, ".sel_chn"},    {15'd0, bus.sel_chn},    {15'd0, chn});
    check({tag, ".sw_pulse"},   {15'd0, bus.sw_pulse},   {15'd0, pulse});
    check({tag, ".sw_cnt"},     {8'd0, bus.sw_cnt},      {8'd0, cnt});
    check({tag, ".drain_busy"}, {15'd0, bus.drain_busy}, {15'd0, drain});
  endtask

  initial begin
    rst_125m = 1'b1;
    bus.chn_a_err  = 1'b0;
    bus.chn_b_err  = 1'b0;
    bus.chn_a_busy = 1'b0;
    bus.chn_b_busy = 1'b0;
    tick(2);
    check_out("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Start-up: eligible after 16 error-free edges, selected on the 17th.
    rst_125m = 1'b0;
    tick(16);
    check_out("startup_wait", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    tick(1);
    check_out("startup_sel_a", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
    tick(1);
    check_out("startup_pulse_end", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);

    // One-cycle A fault: immediate switch to B.
    bus.chn_a_err = 1'b1;
    tick(1);
    bus.chn_a_err = 1'b0;
    check_out("a_fault_to_b", 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
    // B faults while A is still in hold-off (A count 14): no healthy channel.
    tick(14);
    bus.chn_b_err = 1'b1;
    tick(1);
    bus.chn_b_err = 1'b0;
    check_out("b_fault_a_holdoff", 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);
    tick(1);
    check_out("a_still_ineligible", 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);
    tick(1);
    check_out("a_eligible_16_after", 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);

    // Both errors on the same edge, then B recovers first.
    tick(20);
    bus.chn_a_err = 1'b1;
    bus.chn_b_err = 1'b1;
    tick(1);
    check_out("both_err_none", 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);
    bus.chn_b_err = 1'b0;
    tick(16);
    check_out("b_recovering", 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);
    tick(1);
    check_out("b_recovered_sel_b", 1'b1, 1'b1, 1'b1, 8'd4, 1'b0);
    bus.chn_a_err = 1'b0;

`ifdef SLINK_REVERT_EN
    bus.chn_b_busy = 1'b1;
    tick(17);
    check_out("drain_enter", 1'b1, 1'b1, 1'b0, 8'd4, 1'b1);
    tick(23);
    check_out("drain_hold", 1'b1, 1'b1, 1'b0, 8'd4, 1'b1);
    bus.chn_b_busy = 1'b0;
    tick(1);
    check_out("drain_revert_a", 1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    // Back to B, enter DRAIN again, then reset in the middle of it.
    bus.chn_a_err = 1'b1;
    tick(1);
    bus.chn_a_err = 1'b0;
    bus.chn_b_busy = 1'b1;
    check_out("to_b_again", 1'b1, 1'b1, 1'b1, 8'd6, 1'b0);
    tick(20);
    check_out("drain_again", 1'b1, 1'b1, 1'b0, 8'd6, 1'b1);
`else
    // Non-revertive: A recovered, B healthy, B stays selected.
    tick(30);
    check_out("no_revert", 1'b1, 1'b1, 1'b0, 8'd4, 1'b0);
`endif

    rst_125m = 1'b1;
    tick(1);
    check_out("mid_op_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst_125m = 1'b0;
    bus.chn_b_busy = 1'b0;
    tick(16);
    check_out("post_reset_wait", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    tick(1);
    check_out("post_reset_sel_a", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);

    // Drive well over 255 switchovers by alternating one-cycle faults.
    for (int i = 0; i < 150; i++) begin
      bus.chn_a_err = 1'b1;
      tick(1);
      bus.chn_a_err = 1'b0;
      tick(17);
      bus.chn_b_err = 1'b1;
      tick(1);
      bus.chn_b_err = 1'b0;
      tick(17);
    end
    check({"sat", ".sw_cnt"}, {8'd0, bus.sw_cnt}, 16'h00FF);
    check({"sat", ".sel_chn"}, {15'd0, bus.sel_chn}, 16'd0);
    bus.chn_a_err = 1'b1;
    tick(1);
    bus.chn_a_err = 1'b0;
    check_out("sat_hold", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
